// File: rtl/in_scan.sv
// in_scan: time-multiplexed debouncer for slow external inputs; one shared engine
// visits every channel per scan tick and queues level changes on a valid/ready port.
// state | meaning
// IDLE  | waiting for a scan tick (or a pending one)
// SCAN  | evaluating channel idx, one channel per clock
// STALL | channel idx has an event but the output slot is full; retry each clock
module in_scan #(
    parameter int CHANS     = 8,
    parameter int SYNC_W    = 2,
    parameter int TICK_DIV  = 256,
    parameter int DEB_TICKS = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic [CHANS-1:0]         data_i,
    output logic [CHANS-1:0]         level_o,
    output logic                     ev_valid_o,
    input  logic                     ev_ready_i,
    output logic [$clog2(CHANS)-1:0] ev_chan_o,
    output logic                     ev_rise_o,
    output logic                     ovf_o,
    input  logic                     ovf_clr_i
);

    localparam int IDX_W   = $clog2(CHANS);
    localparam int CNT_W   = (DEB_TICKS > 1) ? $clog2(DEB_TICKS) : 1;
    localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [CNT_W-1:0]   CNT_MAX   = CNT_W'(DEB_TICKS - 1);
    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICK_DIV - 1);
    localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(CHANS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        STALL = 2'd2
    } state_t;

    logic [CHANS-1:0]   sync_q [SYNC_W];
    logic [CNT_W-1:0]   cnt_q  [CHANS];
    logic [CHANS-1:0]   level_q;
    logic [PRESC_W-1:0] presc_q;
    logic               tick_q;
    logic               tick_pend_q;
    logic [IDX_W-1:0]   idx_q;
    state_t             state_q;
    logic               ev_valid_q;
    logic [IDX_W-1:0]   ev_chan_q;
    logic               ev_rise_q;
    logic               ovf_q;

    logic               cur_sync;
    logic [CNT_W-1:0]   cur_cnt;
    logic               differ;
    logic               fire;
    logic               slot_busy;
    logic               last_chan;
    logic               ovf_set;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < SYNC_W; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= data_i;
            for (int i = 1; i < SYNC_W; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    // Tick is registered, so the first one lands TICK_DIV clocks after reset release.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            presc_q <= '0;
            tick_q  <= 1'b0;
        end else begin
            presc_q <= (presc_q == PRESC_MAX) ? '0 : presc_q + 1'b1;
            tick_q  <= (presc_q == PRESC_MAX);
        end
    end

    assign cur_sync  = sync_q[SYNC_W-1][idx_q];
    assign cur_cnt   = cnt_q[idx_q];
    assign differ    = (cur_sync != level_q[idx_q]);
    assign fire      = differ && (cur_cnt == CNT_MAX);
    assign slot_busy = ev_valid_q && !ev_ready_i;
    assign last_chan = (idx_q == LAST_IDX);
    assign ovf_set   = tick_q && tick_pend_q && (state_q != IDLE);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            tick_pend_q <= 1'b0;
            level_q     <= '0;
            ev_valid_q  <= 1'b0;
            ev_chan_q   <= '0;
            ev_rise_q   <= 1'b0;
            ovf_q       <= 1'b0;
            for (int c = 0; c < CHANS; c++) cnt_q[c] <= '0;
        end else begin
            if (ovf_set)        ovf_q <= 1'b1;
            else if (ovf_clr_i) ovf_q <= 1'b0;

            // Drain by default; a load in the same clock below takes precedence.
            if (ev_valid_q && ev_ready_i) ev_valid_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (tick_q || tick_pend_q) begin
                        state_q     <= SCAN;
                        idx_q       <= '0;
                        tick_pend_q <= 1'b0;
                    end
                end
                SCAN, STALL: begin
                    if (tick_q) tick_pend_q <= 1'b1;
                    if (fire && slot_busy) begin
                        state_q <= STALL;
                    end else begin
                        if (!differ) begin
                            cnt_q[idx_q] <= '0;
                        end else if (fire) begin
                            cnt_q[idx_q]   <= '0;
                            level_q[idx_q] <= cur_sync;
                            ev_valid_q     <= 1'b1;
                            ev_chan_q      <= idx_q;
                            ev_rise_q      <= cur_sync;
                        end else begin
                            cnt_q[idx_q] <= cur_cnt + 1'b1;
                        end
                        if (last_chan) begin
                            state_q <= IDLE;
                        end else begin
                            state_q <= SCAN;
                            idx_q   <= idx_q + 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign level_o    = level_q;
    assign ev_valid_o = ev_valid_q;
    assign ev_chan_o  = ev_chan_q;
    assign ev_rise_o  = ev_rise_q;
    assign ovf_o      = ovf_q;

endmodule

// File: tb/tb_in_scan.sv
// Bench for in_scan: per-edge reference model derived from the scan timing rules,
// plus directed backpressure, overflow and reset scenarios.
module tb_in_scan;

    localparam int CHANS     = 4;
    localparam int SYNC_W    = 2;
    localparam int TICK_DIV  = 8;
    localparam int DEB_TICKS = 3;
    localparam int IDX_W     = $clog2(CHANS);
    localparam int HN        = 4096;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic [CHANS-1:0] data = '0;
    logic             ev_ready = 1'b1;
    logic             ovf_clr = 1'b0;
    logic [CHANS-1:0] level;
    logic             ev_valid;
    logic [IDX_W-1:0] ev_chan;
    logic             ev_rise;
    logic             ovf;

    int errors = 0;
    int checks = 0;
    int cyc;

    logic [CHANS-1:0] hist [HN];
    logic [CHANS-1:0] exp_lvl;
    int               m_cnt [CHANS];
    logic             exp_valid;
    logic [IDX_W-1:0] exp_chan;
    logic             exp_rise;

    in_scan #(
        .CHANS(CHANS), .SYNC_W(SYNC_W), .TICK_DIV(TICK_DIV), .DEB_TICKS(DEB_TICKS)
    ) dut (
        .clk_i(clk), .rst_n_i(rst_n), .data_i(data), .level_o(level),
        .ev_valid_o(ev_valid), .ev_ready_i(ev_ready), .ev_chan_o(ev_chan),
        .ev_rise_o(ev_rise), .ovf_o(ovf), .ovf_clr_i(ovf_clr)
    );

    always #5 clk = ~clk;

    // Edges counted since reset release; tick k lands on edge k*TICK_DIV.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // Reference model with ev_ready held high: channel c of the scan started by the
    // tick on edge T commits on edge T+2+c, using the input seen SYNC_W+1 edges earlier.
    task automatic model_eval(input int n);
        int   c;
        logic s;
        exp_valid = 1'b0;
        if (n >= TICK_DIV + 2 && ((n - 2) % TICK_DIV) < CHANS) begin
            c = (n - 2) % TICK_DIV;
            s = hist[(n - 1 - SYNC_W) % HN][c];
            if (s == exp_lvl[c]) begin
                m_cnt[c] = 0;
            end else if (m_cnt[c] == DEB_TICKS - 1) begin
                m_cnt[c]   = 0;
                exp_lvl[c] = s;
                exp_valid  = 1'b1;
                exp_chan   = IDX_W'(c);
                exp_rise   = s;
            end else begin
                m_cnt[c] = m_cnt[c] + 1;
            end
        end
    endtask

    task automatic model_reset();
        exp_lvl   = '0;
        exp_valid = 1'b0;
        exp_chan  = '0;
        exp_rise  = 1'b0;
        for (int c = 0; c < CHANS; c++) m_cnt[c] = 0;
    endtask

    task automatic step();
        hist[cyc % HN] = data;
        @(posedge clk);
        #1;
        model_eval(cyc);
    endtask

    task automatic apply_reset(input logic [CHANS-1:0] d);
        rst_n    = 1'b0;
        data     = d;
        ev_ready = 1'b1;
        ovf_clr  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic enter_stall(output bit ok);
        apply_reset('0);
        ev_ready = 1'b0;
        while (cyc % TICK_DIV != CHANS + 2) step();
        data[0]       = 1'b1;
        data[CHANS-1] = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 6 * TICK_DIV && !ok; i++) begin
            step();
            ok = ev_valid;
        end
    endtask

    task automatic test_reset();
        #2;
        data  = CHANS'($urandom);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({level, ev_valid, ev_chan, ev_rise, ovf} !== '0) begin
            errors++;
            $display("FAIL reset_async: level=%b valid=%b chan=%0d rise=%b ovf=%b, want all 0",
                     level, ev_valid, ev_chan, ev_rise, ovf);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        step();
        checks++;
        if ({level, ev_valid, ev_chan, ev_rise, ovf} !== '0) begin
            errors++;
            $display("FAIL reset_release: level=%b valid=%b ovf=%b, want all 0", level, ev_valid, ovf);
        end
    endtask

    task automatic test_quiet();
        apply_reset('0);
        for (int i = 0; i < 200; i++) begin
            step();
            checks++;
            if (ev_valid !== exp_valid || level !== exp_lvl || ovf !== 1'b0) begin
                errors++;
                $display("FAIL quiet cyc=%0d: valid=%b level=%b ovf=%b, want valid=%b level=%b ovf=0",
                         cyc, ev_valid, level, ovf, exp_valid, exp_lvl);
            end
        end
    endtask

    task automatic test_rise();
        int n_ev = 0;
        apply_reset('0);
        repeat ($urandom_range(3, 20)) step();
        data[2] = 1'b1;
        for (int i = 0; i < 6 * TICK_DIV; i++) begin
            step();
            checks++;
            if (ev_valid !== exp_valid || level !== exp_lvl ||
                (exp_valid && (ev_chan !== exp_chan || ev_rise !== exp_rise))) begin
                errors++;
                $display("FAIL rise cyc=%0d: valid=%b chan=%0d rise=%b level=%b, want valid=%b chan=%0d rise=%b level=%b",
                         cyc, ev_valid, ev_chan, ev_rise, level, exp_valid, exp_chan, exp_rise, exp_lvl);
            end
            if (ev_valid === 1'b1) begin
                n_ev++;
                checks++;
                if (level[2] !== 1'b1 || ev_chan !== IDX_W'(2) || ev_rise !== 1'b1) begin
                    errors++;
                    $display("FAIL rise_event: chan=%0d rise=%b level=%b, want chan=2 rise=1 level[2]=1",
                             ev_chan, ev_rise, level);
                end
            end
        end
        checks++;
        if (n_ev != 1) begin
            errors++;
            $display("FAIL rise_count: events=%0d, want 1", n_ev);
        end
    endtask

    task automatic test_glitch();
        apply_reset('0);
        while (cyc % TICK_DIV != CHANS + 2) step();
        for (int i = 0; i < 9 * TICK_DIV; i++) begin
            data[1] = (i < 2 * TICK_DIV) || (i >= 6 * TICK_DIV);
            step();
            checks++;
            if (ev_valid !== exp_valid || level !== exp_lvl ||
                (exp_valid && (ev_chan !== exp_chan || ev_rise !== exp_rise))) begin
                errors++;
                $display("FAIL glitch cyc=%0d: valid=%b chan=%0d rise=%b level=%b, want valid=%b chan=%0d rise=%b level=%b",
                         cyc, ev_valid, ev_chan, ev_rise, level, exp_valid, exp_chan, exp_rise, exp_lvl);
            end
            if (i == 6 * TICK_DIV - 1) begin
                checks++;
                if (level[1] !== 1'b0) begin
                    errors++;
                    $display("FAIL glitch_short: level[1]=%b, want 0", level[1]);
                end
            end
        end
        checks++;
        if (level[1] !== 1'b1) begin
            errors++;
            $display("FAIL glitch_long: level[1]=%b, want 1", level[1]);
        end
    endtask

    task automatic test_stall();
        bit ok;
        enter_stall(ok);
        checks++;
        if (!ok || ev_chan !== '0 || ev_rise !== 1'b1) begin
            errors++;
            $display("FAIL stall_first: seen=%b chan=%0d rise=%b, want seen=1 chan=0 rise=1", ok, ev_chan, ev_rise);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (ev_valid !== 1'b1 || ev_chan !== '0 || ev_rise !== 1'b1 || level !== CHANS'(1)) begin
                errors++;
                $display("FAIL stall_hold: valid=%b chan=%0d rise=%b level=%b, want 1 0 1 %b",
                         ev_valid, ev_chan, ev_rise, level, CHANS'(1));
            end
        end
        ev_ready = 1'b1;
        step();
        checks++;
        if (ev_valid !== 1'b1 || ev_chan !== IDX_W'(CHANS - 1) || ev_rise !== 1'b1 || level !== data) begin
            errors++;
            $display("FAIL stall_release: valid=%b chan=%0d rise=%b level=%b, want 1 %0d 1 %b",
                     ev_valid, ev_chan, ev_rise, level, CHANS - 1, data);
        end
        step();
        checks++;
        if (ev_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_drain: valid=%b, want 0", ev_valid);
        end
    endtask

    task automatic test_ovf();
        bit ok;
        enter_stall(ok);
        repeat (TICK_DIV + 2) step();
        checks++;
        if (!ok || ovf !== 1'b0) begin
            errors++;
            $display("FAIL ovf_one_tick: seen=%b ovf=%b, want seen=1 ovf=0", ok, ovf);
        end
        repeat (2 * TICK_DIV - 2) step();
        checks++;
        if (ovf !== 1'b1 || ev_valid !== 1'b1 || ev_chan !== '0) begin
            errors++;
            $display("FAIL ovf_set: ovf=%b valid=%b chan=%0d, want 1 1 0", ovf, ev_valid, ev_chan);
        end
        ev_ready = 1'b1;
        repeat (3 * TICK_DIV) step();
        checks++;
        if (ovf !== 1'b1 || level !== data) begin
            errors++;
            $display("FAIL ovf_sticky: ovf=%b level=%b, want ovf=1 level=%b", ovf, level, data);
        end
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        checks++;
        if (ovf !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear: ovf=%b, want 0", ovf);
        end
    endtask

    task automatic test_reset_mid_stall();
        bit ok;
        int first_ev = -1;
        enter_stall(ok);
        repeat (3 * TICK_DIV) step();
        checks++;
        if (!ok || ev_valid !== 1'b1 || ovf !== 1'b1) begin
            errors++;
            $display("FAIL midstall_pre: seen=%b valid=%b ovf=%b, want 1 1 1", ok, ev_valid, ovf);
        end
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (ev_valid !== 1'b0 || level !== '0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL midstall_async: valid=%b level=%b ovf=%b, want all 0", ev_valid, level, ovf);
        end
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        ev_ready = 1'b1;
        model_reset();
        for (int i = 0; i < 5 * TICK_DIV; i++) begin
            step();
            checks++;
            if (ev_valid !== exp_valid || level !== exp_lvl ||
                (exp_valid && (ev_chan !== exp_chan || ev_rise !== exp_rise))) begin
                errors++;
                $display("FAIL post_reset cyc=%0d: valid=%b chan=%0d rise=%b level=%b, want valid=%b chan=%0d rise=%b level=%b",
                         cyc, ev_valid, ev_chan, ev_rise, level, exp_valid, exp_chan, exp_rise, exp_lvl);
            end
            if (ev_valid === 1'b1 && first_ev < 0) first_ev = cyc;
        end
        checks++;
        if (first_ev != DEB_TICKS * TICK_DIV + 2) begin
            errors++;
            $display("FAIL first_tick: first event on edge %0d, want %0d", first_ev, DEB_TICKS * TICK_DIV + 2);
        end
    endtask

    task automatic test_back_to_back();
        logic [CHANS-1:0] mask;
        int               got_n [CHANS];
        logic             got_r [CHANS];
        apply_reset('0);
        for (int r = 0; r < 6; r++) begin
            mask = CHANS'($urandom_range(1, (1 << CHANS) - 1));
            data = data ^ mask;
            for (int c = 0; c < CHANS; c++) begin
                got_n[c] = 0;
                got_r[c] = 1'bx;
            end
            for (int i = 0; i < 12 * TICK_DIV; i++) begin
                ev_ready = 1'($urandom_range(0, 1));
                if (ev_valid === 1'b1 && ev_ready) begin
                    got_n[ev_chan] = got_n[ev_chan] + 1;
                    got_r[ev_chan] = ev_rise;
                end
                step();
            end
            ev_ready = 1'b1;
            for (int c = 0; c < CHANS; c++) begin
                checks++;
                if (got_n[c] != int'(mask[c]) || (mask[c] && got_r[c] !== data[c])) begin
                    errors++;
                    $display("FAIL b2b round=%0d ch=%0d: events=%0d rise=%b, want events=%0d rise=%b",
                             r, c, got_n[c], got_r[c], mask[c], data[c]);
                end
            end
            checks++;
            if (level !== data) begin
                errors++;
                $display("FAIL b2b_level round=%0d: level=%b, want %b", r, level, data);
            end
        end
    endtask

    task automatic test_random();
        apply_reset('0);
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 5) == 0) data[$urandom_range(0, CHANS - 1)] ^= 1'b1;
            step();
            checks++;
            if (ev_valid !== exp_valid || level !== exp_lvl || ovf !== 1'b0 ||
                (exp_valid && (ev_chan !== exp_chan || ev_rise !== exp_rise))) begin
                errors++;
                $display("FAIL random cyc=%0d: valid=%b chan=%0d rise=%b level=%b ovf=%b, want valid=%b chan=%0d rise=%b level=%b ovf=0",
                         cyc, ev_valid, ev_chan, ev_rise, level, ovf, exp_valid, exp_chan, exp_rise, exp_lvl);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_quiet();
        test_rise();
        test_glitch();
        test_stall();
        test_ovf();
        test_reset_mid_stall();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/in_scan.md
# in_scan

Time-multiplexed debouncer and event scheduler for a bank of slow external inputs such as buttons, switches and encoder contacts.
- A shared scan engine visits each channel once per scan tick and runs a per-channel debounce count.
- It keeps a debounced level vector and queues level changes as (channel, direction) events on a valid/ready port for the processor-side register interface.
- It sits between the raw pad inputs and the processor I/O space.

## Interface
- CHANS, 8, number of input channels (2 min)
- SYNC_W, 2, resync register stages per input (1 min)
- TICK_DIV, 256, clocks per scan tick (CHANS+2 min)
- DEB_TICKS, 4, consecutive mismatching scans required to flip a level (1 min)
- clk_i  in  1  clock
- rst_n_i  in  1  reset; asynchronous, active-low
- data_i  in  CHANS  raw asynchronous inputs
- level_o  out  CHANS  debounced levels
- ev_valid_o  out  1  event available
- ev_ready_i  in  1  consumer accepts event
- ev_chan_o  out  $clog2(CHANS)  channel of event
- ev_rise_o  out  1  1=new level high, 0=new level low
- ovf_o  out  1  sticky: scan tick lost
- ovf_clr_i  in  1  clears ovf_o

## Operation
- **Input resync:** every data_i bit passes through SYNC_W flops. The sync output is sync[c].
- **Prescaler:** counts 0..TICK_DIV-1 and wraps. Terminal count asserts tick for one clock.
- **State machine:** IDLE, SCAN, STALL.
  - IDLE → SCAN on tick, or when tick_pend=1. The scan index is set to 0 and tick_pend is cleared.
  - SCAN evaluates channel idx in one clock.
    - After idx=CHANS-1 the machine returns to IDLE.
    - Otherwise idx increments.
  - SCAN → STALL when evaluation of idx produces an event and the output slot is occupied and not draining (ev_valid_o & ~ev_ready_i). Nothing for idx is committed.
  - STALL re-evaluates idx each clock and commits once the slot frees, then continues as SCAN.
- **Per-channel evaluation:** cnt[c] is $clog2(DEB_TICKS) bits wide (1 bit min).
  - If sync[c]==level[c]: cnt[c]←0.
  - Else if cnt[c]==DEB_TICKS-1: level[c]←sync[c], cnt[c]←0, and an event (c, sync[c]) is emitted.
  - Else cnt[c]←cnt[c]+1.
- **Output slot:** a single registered entry.
  - It loads when empty or when ev_valid_o & ev_ready_i in the same clock, which allows back-to-back events with no bubble.
  - ev_chan_o and ev_rise_o hold stable while ev_valid_o=1 & ev_ready_i=0.
- **Ticks outside IDLE:** a tick arriving in SCAN or STALL sets tick_pend.
  - If tick_pend is already 1, ovf_o←1.
  - On ovf_clr_i with a coincident overflow, set wins.
- **Ordering:** events within one scan emerge in ascending channel order. No event is ever dropped; backpressure stalls the scan instead.

## Timing
- **Reset values (asynchronous, while rst_n_i=0):**
  - level_o=0, ev_valid_o=0, ev_chan_o=0, ev_rise_o=0, ovf_o=0.
  - All cnt, sync flops, prescaler, idx and tick_pend are 0; state is IDLE.
- **Reset release:** the first tick occurs at clock TICK_DIV after rst_n_i deasserts.
- **Scan timing:** for a tick at clock T, channel c is evaluated at clock T+1+c, absent stalls.
- **Event timing:** level_o[c] and ev_valid_o update at the edge ending the evaluation clock, i.e. visible at T+2+c.
- **Input-to-level latency:** SYNC_W clocks of resync, plus up to DEB_TICKS scans, plus the scan offset.
- **Scan length:** an unstalled scan occupies CHANS clocks, always less than TICK_DIV, so no tick is pending without backpressure.
- **Stall length:** the stall lasts until the clock ev_ready_i is high. The commit happens in that same clock.
- **Reset mid-stall or mid-scan:** everything returns to reset values immediately. A pending event is discarded.

## Test plan
1. CHANS=4, TICK_DIV=8, DEB_TICKS=3, data_i=0 for 200 clocks → level_o=0, ev_valid_o never 1, ovf_o=0.
2. data_i[2] 0→1 and held, ev_ready_i=1 → exactly one event ev_chan_o=2, ev_rise_o=1, on the 3rd scan evaluating ch2 after sync. level_o[2]=1 in the same cycle ev_valid_o rises.
3. data_i[1] high for 2 ticks, then low → no event, level_o[1] stays 0. A later 3-tick high does flip it, confirming the count reset.
4. ev_ready_i=0; ch0 and ch3 rise together → ch0 event held stable and the FSM is in STALL at idx=3. Raise ev_ready_i → ch0 accepted, ch3 presented the next clock, no loss, ascending order.
5. ev_ready_i=0 held for 3*TICK_DIV with a stall active → ovf_o=1. Pulse ovf_clr_i with no new overflow → ovf_o=0 the next clock.
6. Assert rst_n_i=0 during STALL with ev_valid_o=1 → ev_valid_o, level_o and ovf_o all 0 asynchronously. After release, the first tick comes at TICK_DIV clocks.
